// File: rtl/vme_request_decoder.sv
// vme_request_decoder: strobe sync, address/fc window decode, request watchdog
module vme_request_decoder #(
  parameter logic [15:0] A16_PREFIX     = 16'hFFFF,
  parameter logic [7:0]  A24_PREFIX     = 8'hFF,
  parameter logic        A40_PREFIX     = 1'b1,
  parameter bit          ENABLE_A40     = 1'b0,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_as,
  input  logic [15:0] cpu_address,
  input  logic [2:0]  cpu_fc,
  input  logic [1:0]  cpu_dsack,
  output logic        request_vme,
  output logic        request_vme_a16,
  output logic        request_vme_a24,
  output logic        request_vme_a40,
  output logic        bus_timeout,
  output logic [7:0]  timeout_count
);
  typedef enum logic [1:0] {IDLE, REQUEST, TIMEOUT, WAIT_RELEASE} state_t;
  state_t      state, state_d;
  logic        as_meta, as_sync;
  logic [15:0] addr_q, addr_d, timer;
  logic [2:0]  fc_q, fc_d;
  logic        latch, hit16, hit24, hit40, hit, expire;
  // Decode always works on the latched view; on the capture edge that is the incoming value.
  always_comb begin
    latch   = state == IDLE && !as_sync;
    addr_d  = latch ? cpu_address : addr_q;
    fc_d    = latch ? cpu_fc : fc_q;
    hit16   = addr_d == A16_PREFIX;
    hit24   = !hit16 && addr_d[15:8] == A24_PREFIX;
    hit40   = !hit16 && !hit24 && ENABLE_A40 && addr_d[15] == A40_PREFIX;
    hit     = fc_d != 3'b111 && (hit16 || hit24 || hit40);
    expire  = cpu_dsack == 2'b11 && timer == 16'(TIMEOUT_CYCLES - 1);
    state_d = state == IDLE    ? (as_sync ? IDLE : hit ? REQUEST : WAIT_RELEASE) :
              state == REQUEST ? (as_sync ? IDLE : expire ? TIMEOUT : REQUEST) :
              (state == TIMEOUT || state == WAIT_RELEASE) ? (as_sync ? IDLE : state) : IDLE;
  end
  // Synchroniser, FSM, watchdog and registered active-low outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      as_meta         <= 1'b1;
      as_sync         <= 1'b1;
      state           <= IDLE;
      addr_q          <= '0;
      fc_q            <= '0;
      timer           <= '0;
      timeout_count   <= '0;
      request_vme     <= 1'b1;
      request_vme_a16 <= 1'b1;
      request_vme_a24 <= 1'b1;
      request_vme_a40 <= 1'b1;
      bus_timeout     <= 1'b1;
    end else begin
      as_meta         <= cpu_as;
      as_sync         <= as_meta;
      state           <= state_d;
      addr_q          <= addr_d;
      fc_q            <= fc_d;
      timer           <= latch ? '0 :
                         (state == REQUEST && state_d == REQUEST && cpu_dsack == 2'b11) ? timer + 16'd1 : timer;
      timeout_count   <= (state == REQUEST && state_d == TIMEOUT && timeout_count != 8'hFF) ?
                         timeout_count + 8'd1 : timeout_count;
      request_vme     <= state_d != REQUEST;
      request_vme_a16 <= !(state_d == REQUEST && hit16);
      request_vme_a24 <= !(state_d == REQUEST && hit24);
      request_vme_a40 <= !(state_d == REQUEST && hit40);
      bus_timeout     <= state_d != TIMEOUT;
    end
  end
endmodule

// File: tb/tb_vme_request_decoder.sv
// tb_vme_request_decoder: randomized self-check of two decoder configurations against an access-level model
module tb_vme_request_decoder;
  localparam int TA = 1000;
  localparam int TB = 8;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_as = 1'b1;
  logic [15:0] cpu_address = '0;
  logic [2:0]  cpu_fc = '0;
  logic [1:0]  cpu_dsack = 2'b11;
  logic        a_req, a_16, a_24, a_40, a_bt, b_req, b_16, b_24, b_40, b_bt;
  logic [7:0]  a_cnt, b_cnt;
  logic [12:0] obs_a [0:63];
  logic [12:0] obs_b [0:63];
  int          total = 0;
  int          bad = 0;
  int          base_a = 0;
  int          base_b = 0;

  vme_request_decoder u_a (
    .clock(clock), .reset(reset), .cpu_as(cpu_as), .cpu_address(cpu_address), .cpu_fc(cpu_fc),
    .cpu_dsack(cpu_dsack), .request_vme(a_req), .request_vme_a16(a_16), .request_vme_a24(a_24),
    .request_vme_a40(a_40), .bus_timeout(a_bt), .timeout_count(a_cnt)
  );
  vme_request_decoder #(.ENABLE_A40(1'b1), .TIMEOUT_CYCLES(TB)) u_b (
    .clock(clock), .reset(reset), .cpu_as(cpu_as), .cpu_address(cpu_address), .cpu_fc(cpu_fc),
    .cpu_dsack(cpu_dsack), .request_vme(b_req), .request_vme_a16(b_16), .request_vme_a24(b_24),
    .request_vme_a40(b_40), .bus_timeout(b_bt), .timeout_count(b_cnt)
  );

  always #5 clock = ~clock;

  // Expected {req, a16, a24, a40, bus_timeout, count} after edge k of an access that holds the
  // strobe for h edges and turns DSACK on after edge d (d==0: never).
  function automatic logic [12:0] model(int t, bit en, logic [15:0] addr, logic [2:0] fc,
                                        int h, int d, int k, int base);
    logic [2:0] w;
    bit to, act, tl;
    int c;
    w   = (fc == 3'b111) ? 3'b000 : (addr == 16'hFFFF) ? 3'b100 :
          (addr[15:8] == 8'hFF) ? 3'b010 : (en && addr[15]) ? 3'b001 : 3'b000;
    to  = w != 0 && (d == 0 || d >= 3 + t) && t < h;
    act = w != 0 && k >= 3 && k < h + 3 && !(to && k >= 3 + t);
    tl  = to && k >= 3 + t && k < h + 3;
    c   = (to && k >= 3 + t) ? ((base < 255) ? base + 1 : 255) : base;
    return {~act, ~(act && w[2]), ~(act && w[1]), ~(act && w[0]), ~tl, 8'(c)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_access(input logic [15:0] addr, input logic [2:0] fc, input int h, input int d);
    cpu_address = addr;
    cpu_fc = fc;
    cpu_dsack = 2'b11;
    cpu_as = 1'b0;
    for (int k = 1; k <= h + 4; k++) begin
      tick();
      obs_a[k] = {a_req, a_16, a_24, a_40, a_bt, a_cnt};
      obs_b[k] = {b_req, b_16, b_24, b_40, b_bt, b_cnt};
      if (k == h) cpu_as = 1'b1;
      if (k == d) cpu_dsack = 2'b01;
    end
    cpu_dsack = 2'b11;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cpu_as = 1'b1;
    repeat (3) tick();
    total++;
    if ({a_req, a_16, a_24, a_40, a_bt, a_cnt} !== {5'b11111, 8'd0}) begin
      bad++;
      $display("FAIL reset u_a: got %h expected %h", {a_req, a_16, a_24, a_40, a_bt, a_cnt}, {5'b11111, 8'd0});
    end
    total++;
    if ({b_req, b_16, b_24, b_40, b_bt, b_cnt} !== {5'b11111, 8'd0}) begin
      bad++;
      $display("FAIL reset u_b: got %h expected %h", {b_req, b_16, b_24, b_40, b_bt, b_cnt}, {5'b11111, 8'd0});
    end
    reset = 1'b1;
    repeat (2) tick();
    base_a = 0;
    base_b = 0;
  endtask

  task automatic test_a24_normal();
    logic [12:0] ea, eb;
    drive_access(16'hFF12, 3'b101, 20, 10);
    for (int k = 1; k <= 24; k++) begin
      ea = model(TA, 1'b0, 16'hFF12, 3'b101, 20, 10, k, base_a);
      eb = model(TB, 1'b1, 16'hFF12, 3'b101, 20, 10, k, base_b);
      total += 2;
      if (obs_a[k] !== ea) begin bad++; $display("FAIL a24_normal u_a edge %0d: got %h expected %h", k, obs_a[k], ea); end
      if (obs_b[k] !== eb) begin bad++; $display("FAIL a24_normal u_b edge %0d: got %h expected %h", k, obs_b[k], eb); end
    end
  endtask

  task automatic test_a16_priority();
    logic [12:0] ea, eb;
    drive_access(16'hFFFF, 3'b110, 6, 4);
    for (int k = 1; k <= 10; k++) begin
      ea = model(TA, 1'b0, 16'hFFFF, 3'b110, 6, 4, k, base_a);
      eb = model(TB, 1'b1, 16'hFFFF, 3'b110, 6, 4, k, base_b);
      total += 2;
      if (obs_a[k] !== ea) begin bad++; $display("FAIL a16_priority u_a edge %0d: got %h expected %h", k, obs_a[k], ea); end
      if (obs_b[k] !== eb) begin bad++; $display("FAIL a16_priority u_b edge %0d: got %h expected %h", k, obs_b[k], eb); end
    end
  endtask

  task automatic test_unmapped();
    logic [15:0] addrs [3] = '{16'h1234, 16'hFF00, 16'h8000};
    logic [2:0]  fcs [3] = '{3'b101, 3'b111, 3'b001};
    logic [12:0] ea, eb;
    for (int i = 0; i < 3; i++) begin
      drive_access(addrs[i], fcs[i], 7, 0);
      for (int k = 1; k <= 11; k++) begin
        ea = model(TA, 1'b0, addrs[i], fcs[i], 7, 0, k, base_a);
        eb = model(TB, 1'b1, addrs[i], fcs[i], 7, 0, k, base_b);
        total += 2;
        if (obs_a[k] !== ea) begin bad++; $display("FAIL unmapped%0d u_a edge %0d: got %h expected %h", i, k, obs_a[k], ea); end
        if (obs_b[k] !== eb) begin bad++; $display("FAIL unmapped%0d u_b edge %0d: got %h expected %h", i, k, obs_b[k], eb); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [12:0] ea, eb;
    drive_access(16'hFF40, 3'b010, 20, 0);
    for (int k = 1; k <= 24; k++) begin
      ea = model(TA, 1'b0, 16'hFF40, 3'b010, 20, 0, k, base_a);
      eb = model(TB, 1'b1, 16'hFF40, 3'b010, 20, 0, k, base_b);
      total += 2;
      if (obs_a[k] !== ea) begin bad++; $display("FAIL timeout u_a edge %0d: got %h expected %h", k, obs_a[k], ea); end
      if (obs_b[k] !== eb) begin bad++; $display("FAIL timeout u_b edge %0d: got %h expected %h", k, obs_b[k], eb); end
    end
    total++;
    if ({obs_b[10][12], obs_b[11][12], obs_b[11][8], obs_b[11][7:0]} !== {1'b0, 1'b1, 1'b0, 8'(base_b + 1)}) begin
      bad++;
      $display("FAIL timeout_edge u_b: got %h/%h expected drop at edge 11", obs_b[10], obs_b[11]);
    end
    base_b = base_b + 1;
  endtask

  task automatic test_collision();
    logic [12:0] ea, eb;
    for (int h = 8; h <= 9; h++) begin
      drive_access(16'hFF77, 3'b001, h, 0);
      for (int k = 1; k <= h + 4; k++) begin
        ea = model(TA, 1'b0, 16'hFF77, 3'b001, h, 0, k, base_a);
        eb = model(TB, 1'b1, 16'hFF77, 3'b001, h, 0, k, base_b);
        total += 2;
        if (obs_a[k] !== ea) begin bad++; $display("FAIL collision h=%0d u_a edge %0d: got %h expected %h", h, k, obs_a[k], ea); end
        if (obs_b[k] !== eb) begin bad++; $display("FAIL collision h=%0d u_b edge %0d: got %h expected %h", h, k, obs_b[k], eb); end
      end
      base_b = int'(model(TB, 1'b1, 16'hFF77, 3'b001, h, 0, h + 4, base_b) & 13'hFF);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] addr;
    logic [2:0]  fc;
    logic [12:0] eb;
    int          h;
    for (int i = 0; i < 300; i++) begin
      addr = ($urandom_range(0, 1) == 0) ? 16'hFFFF : {8'hFF, 8'($urandom_range(0, 254))};
      fc = 3'($urandom_range(0, 6));
      h = $urandom_range(9, 14);
      drive_access(addr, fc, h, 0);
      for (int k = 1; k <= h + 4; k++) begin
        eb = model(TB, 1'b1, addr, fc, h, 0, k, base_b);
        total++;
        if (obs_b[k] !== eb) begin bad++; $display("FAIL saturation #%0d u_b edge %0d: got %h expected %h", i, k, obs_b[k], eb); end
      end
      base_b = int'(model(TB, 1'b1, addr, fc, h, 0, h + 4, base_b) & 13'hFF);
    end
    total++;
    if (b_cnt !== 8'hFF) begin bad++; $display("FAIL saturation_final: got %h expected ff", b_cnt); end
  endtask

  task automatic test_reset_mid();
    cpu_address = 16'hFF34;
    cpu_fc = 3'b101;
    cpu_dsack = 2'b11;
    cpu_as = 1'b0;
    repeat (5) tick();
    total++;
    if ({a_req, a_24, b_req, b_24} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid_pre: got %b expected 0000", {a_req, a_24, b_req, b_24});
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++;
    if ({a_req, a_16, a_24, a_40, a_bt, a_cnt, b_req, b_16, b_24, b_40, b_bt, b_cnt} !== {5'b11111, 8'd0, 5'b11111, 8'd0}) begin
      bad++;
      $display("FAIL reset_mid_edge: got a=%h b=%h expected 1f00 both",
               {a_req, a_16, a_24, a_40, a_bt, a_cnt}, {b_req, b_16, b_24, b_40, b_bt, b_cnt});
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if ({a_req, a_24, b_req, b_24} !== ((k < 3) ? 4'b1111 : 4'b0000)) begin
        bad++;
        $display("FAIL reset_mid_reassert edge %0d: got %b expected %b", k, {a_req, a_24, b_req, b_24},
                 (k < 3) ? 4'b1111 : 4'b0000);
      end
    end
    cpu_as = 1'b1;
    repeat (4) tick();
    base_a = 0;
    base_b = 0;
  endtask

  task automatic test_random();
    logic [15:0] addr;
    logic [2:0]  fc;
    logic [12:0] ea, eb;
    int          h, d, sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      addr = (sel == 0) ? 16'hFFFF : (sel == 1) ? {8'hFF, 8'($urandom)} :
             (sel == 2) ? {1'b1, 15'($urandom)} : 16'($urandom);
      fc = 3'($urandom_range(0, 7));
      h = $urandom_range(1, 15);
      d = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 18);
      drive_access(addr, fc, h, d);
      for (int k = 1; k <= h + 4; k++) begin
        ea = model(TA, 1'b0, addr, fc, h, d, k, base_a);
        eb = model(TB, 1'b1, addr, fc, h, d, k, base_b);
        total += 2;
        if (obs_a[k] !== ea) begin bad++; $display("FAIL random #%0d u_a edge %0d: got %h expected %h", i, k, obs_a[k], ea); end
        if (obs_b[k] !== eb) begin bad++; $display("FAIL random #%0d u_b edge %0d: got %h expected %h", i, k, obs_b[k], eb); end
      end
      base_b = int'(model(TB, 1'b1, addr, fc, h, d, h + 4, base_b) & 13'hFF);
    end
  endtask

  initial begin
    test_reset();
    test_a24_normal();
    test_a16_priority();
    test_unmapped();
    test_timeout();
    test_collision();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vme_request_decoder.md
# vme_request_decoder

Upstream stage for the VME data-transfer state machine. Synchronises the CPU address strobe, decodes the latched CPU address and function code into the active-low request lines (`request_vme`, `request_vme_a16`, `request_vme_a24`, `request_vme_a40`) that start a VME cycle. A watchdog drops the request if the cycle is not acknowledged in time, which makes the transfer stage end the cycle or raise `cpu_berr`.

## Interface
- `A16_PREFIX`, default 16'hFFFF: `cpu_address[31:16]` value selecting the A16 window.
- `A24_PREFIX`, default 8'hFF: `cpu_address[31:24]` value selecting the A24 window.
- `A40_PREFIX`, default 1'b1: `cpu_address[31]` value selecting the A40 window.
- `ENABLE_A40`, default 0: when 0, the A40 window never matches.
- `TIMEOUT_CYCLES`, default 1000: clocks from request to forced drop; legal range 2..65535.

Ports:
- `clock`, in, 1: system clock. One clock domain.
- `reset`, in, 1: synchronous, active-low.
- `cpu_as`, in, 1: CPU address strobe, active-low, asynchronous.
- `cpu_address`, in, 16: CPU A[31:16]. Stable while `cpu_as` is active.
- `cpu_fc`, in, 3: CPU function code.
- `cpu_dsack`, in, 2: DSACK from the transfer stage, active-low. Used only to stop the watchdog.
- `request_vme`, out, 1: any VME request, active-low.
- `request_vme_a16`, `request_vme_a24`, `request_vme_a40`, out, 1 each: window-specific requests, active-low.
- `bus_timeout`, out, 1: active-low. Held from the timeout until the strobe is released.
- `timeout_count`, out, 8: saturating count of timeouts since reset.

## Operation
- **Strobe synchroniser:** 2-flop synchroniser on `cpu_as` produces `as_sync`. Both flops reset to 1.
- **States:** IDLE, REQUEST, TIMEOUT, WAIT_RELEASE.
- **Reset values:**
  - State = IDLE.
  - All request outputs = 1. `bus_timeout` = 1.
  - Timer = 0. `timeout_count` = 0.
  - Latched address and fc = 0.
- **IDLE:** all requests inactive and `bus_timeout` = 1. When `as_sync` = 0:
  - Latch `cpu_address` and `cpu_fc`. Decode from the latched values only.
  - `cpu_fc` = 3'b111 (CPU space) → WAIT_RELEASE, no request.
  - Window priority is A16 > A24 > A40, so an A16 hit never also raises A24.
  - On a hit → REQUEST. Drive `request_vme` = 0 and exactly one window line = 0. Clear the timer.
  - No hit → WAIT_RELEASE, no request.
- **REQUEST:** requests held.
  - If `as_sync` = 1 → IDLE. Requests go inactive on the same edge.
  - Else, while `cpu_dsack` = 2'b11, the timer increments by 1 per clock.
  - Once any `cpu_dsack` bit is 0, the timer holds.
  - Timer = TIMEOUT_CYCLES−1 with `cpu_dsack` = 2'b11 → TIMEOUT:
    - All requests go to 1.
    - `bus_timeout` goes to 0.
    - `timeout_count` increments, saturating at 8'hFF.
  - Strobe release takes precedence over timeout on the same clock.
- **TIMEOUT:** requests inactive, `bus_timeout` = 0. On `as_sync` = 1 → IDLE, `bus_timeout` = 1.
- **WAIT_RELEASE:** outputs inactive. On `as_sync` = 1 → IDLE.
- **Illegal state encoding:** → IDLE with all outputs inactive.
- **Timer width:** 16 bits. It never wraps, because the exit compare fires first.

## Timing
- **Edge numbering:** edge 1 is the first rising edge at which `cpu_as` = 0 is sampled.
  - `as_sync` = 0 after edge 2.
  - Requests are registered 0 at edge 3.
- **Release latency:** requests go inactive at the 3rd edge after `cpu_as` returns to 1.
- **Timeout edge:** the request is dropped at exactly TIMEOUT_CYCLES edges after it was asserted, provided DSACK never went active.
- **No back-to-back request:** a new request needs IDLE to see `as_sync` = 0 again. Minimum one IDLE cycle between requests.
- **Reset mid-operation:**
  - Outputs go to reset values on the edge that samples `reset` = 0. This includes `timeout_count`.
  - If `cpu_as` is still 0 after reset releases, the cycle is re-decoded normally (3 edges).
- **Register timing:** all outputs are registered. No combinational path from any input to any output.

## Test plan
- **A24 normal:** `cpu_address` = 16'hFF12, `cpu_fc` = 3'b101, `cpu_as` = 0; `cpu_dsack` = 2'b01 at 10 clocks; `cpu_as` = 1 at 20 clocks.
  - `request_vme` = `request_vme_a24` = 0 from edge 3. `a16`/`a40` stay 1.
  - Requests are 1 three edges after the release. `bus_timeout` stays 1 throughout.
- **A16 priority:** `cpu_address` = 16'hFFFF.
  - Only `request_vme_a16` and `request_vme` go 0.
- **Unmapped / CPU space / A40 disabled:** run each with `ENABLE_A40` = 0:
  - `cpu_address` = 16'h1234.
  - `cpu_fc` = 3'b111 with `cpu_address` = 16'hFF00.
  - `cpu_address` = 16'h8000.
  - Required: no request output toggles in any case, and the FSM returns to IDLE after release.
- **Timeout:** `TIMEOUT_CYCLES` = 8, A24 access, `cpu_dsack` held 2'b11.
  - Requests drop to 1 exactly 8 edges after assertion.
  - `bus_timeout` = 0 and `timeout_count` = 1 on that edge.
  - After release, `bus_timeout` = 1.
  - 300 further timeouts → `timeout_count` = 8'hFF.
- **Release vs timeout collision:** `cpu_as` release timed so `as_sync` = 1 on the timeout edge.
  - → IDLE, `bus_timeout` stays 1, `timeout_count` unchanged.
- **Reset mid-REQUEST:** `reset` = 0 for one clock while requests are active and `cpu_as` is held 0.
  - All outputs are 1 and `timeout_count` = 0 after that edge.
  - Requests reassert 3 edges after `reset` returns to 1.
